// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - iterative one-bit-per-clock shifter with valid/ready handshakes
// Serial counterpart of the barrel shifter: logical or rotate, left or right.
module seq_shift_unit #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic             in_dir,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_step;
   logic             dir_q;
   logic             mode_q;
   logic             accept;

   assign accept    = in_valid & in_ready;
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   // The register doubles as the result holder, so the last result stays visible in IDLE.
   assign out_data  = r;

   always_comb begin
      r_step = r;
      case ({mode_q, dir_q})
         2'b00:   r_step = {r[WIDTH-2:0], 1'b0};
         2'b01:   r_step = {1'b0, r[WIDTH-1:1]};
         2'b10:   r_step = {r[WIDTH-2:0], r[WIDTH-1]};
         default: r_step = {r[0], r[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = (in_shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (count == SHW'(1)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         r      <= '0;
         dir_q  <= 1'b0;
         mode_q <= 1'b0;
      end else if (accept) begin
         count  <= in_shamt;
         r      <= in_data;
         dir_q  <= in_dir;
         mode_q <= in_mode;
      end else if (state == SHIFT) begin
         count <= count - SHW'(1);
         r     <= r_step;
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - self-checking bench for seq_shift_unit
// Directed vectors, randomized commands against an arithmetic model, and multi-cycle corner cases.
module tb_seq_shift_unit;

   localparam int W = 8;
   localparam int S = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [S-1:0] in_shamt;
   logic         in_dir;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] data;
      int           shamt;
      logic         dir;
      logic         mode;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[7];

   seq_shift_unit #(.WIDTH(W), .SHW(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_dir    (in_dir),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Shift by s as a single arithmetic operation; rotation wraps the bits pushed off the end.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                          input logic dir, input logic mode);
      int v;
      int res;
      v = int'(d);
      if (!dir) res = (v << s) | (mode ? (v >> (W - s)) : 0);
      else      res = (v >> s) | (mode ? (v << (W - s)) : 0);
      return res[W-1:0];
   endfunction

   // Issue a command after a falling edge and count edges until the result shows.
   task automatic run_cmd(input string name, input logic [W-1:0] d, input int s,
                          input logic dir, input logic mode, input logic [W-1:0] exp);
      int cycles;
      @(negedge clk);
      check({name, " in_ready before accept"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = S'(s);
      in_dir   = dir;
      in_mode  = mode;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_shamt = S'($urandom);
      in_dir   = 1'($urandom);
      in_mode  = 1'($urandom);
      cycles = 1;
      while (!out_valid && cycles < 40) begin
         check({name, " in_ready low while shifting"}, in_ready, 0);
         @(negedge clk);
         cycles++;
      end
      check({name, " latency"}, cycles, s + 1);
      check({name, " out_data"}, out_data, exp);
      check({name, " busy in DONE"}, busy, 1);
      @(negedge clk);
      check({name, " back to idle"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      vecs[0] = '{8'hFF, 5, 1'b0, 1'b0, 8'hE0};
      vecs[1] = '{8'hFF, 3, 1'b1, 1'b0, 8'h1F};
      vecs[2] = '{8'hFF, 1, 1'b1, 1'b0, 8'h7F};
      vecs[3] = '{8'h96, 3, 1'b0, 1'b1, 8'hB4};
      vecs[4] = '{8'h96, 3, 1'b1, 1'b1, 8'hD2};
      vecs[5] = '{8'h01, 7, 1'b0, 1'b1, 8'h80};
      vecs[6] = '{8'hA5, 0, 1'b0, 1'b0, 8'hA5};

      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h3C;
      in_shamt = 3'd2;
      in_dir = 1'b0;
      in_mode = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
      in_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_cmd($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt,
                 vecs[i].dir, vecs[i].mode, vecs[i].exp);
      end

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] d;
         int           s;
         logic         dr;
         logic         md;
         d  = W'($urandom);
         s  = int'($urandom_range(0, 7));
         dr = 1'($urandom);
         md = 1'($urandom);
         run_cmd($sformatf("rand%0d", i), d, s, dr, md, model(d, s, dr, md));
      end

      // Backpressure: result must hold while the consumer stalls and new commands are ignored.
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hC3;
      in_shamt = 3'd2;
      in_dir = 1'b1;
      in_mode = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10 && !out_valid; i++) begin
         in_data = W'($urandom);
         @(negedge clk);
      end
      check("bp out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         in_data  = W'($urandom);
         in_shamt = S'($urandom);
         @(negedge clk);
         check("bp hold", {out_valid, in_ready, out_data}, {2'b10, 8'hF0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release", {in_ready, out_valid, out_data}, {2'b10, 8'hF0});

      // Reset mid-shift aborts the command with no result.
      in_valid = 1'b1;
      in_data = 8'h81;
      in_shamt = 3'd7;
      in_dir = 1'b0;
      in_mode = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid-shift busy", busy, 1);
      rst_n = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("abort outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
      @(negedge clk);
      check("valid ignored in reset", {in_ready, busy}, 2'b10);
      in_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no aborted result", out_valid, 0);
      end
      run_cmd("after abort", 8'h5A, 4, 1'b0, 1'b1, 8'hA5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
